// File: rtl/neural_network_pkg.sv
// Shared types and helpers for the adder-chain front end.
package neural_network_pkg;

    localparam int DEFAULT_ADDEND_WIDTH = 16;

    typedef logic [DEFAULT_ADDEND_WIDTH-1:0] addend_t;

    // Life cycle of one ping-pong buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    // Bits needed to hold a lane count in the range 0..n.
    function automatic int lane_count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/addend_vector_bank.sv
// One vector buffer: lane storage, lane count and EMPTY/FILLING/FULL state.
// A write and a clear never target the same bank in the same cycle.
module addend_vector_bank
    import neural_network_pkg::*;
#(
    parameter int ADDEND_WIDTH      = 16,
    parameter int NUMBER_OF_ADDENDS = 64
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_wr_en,
    input  logic [$clog2(NUMBER_OF_ADDENDS)-1:0]          i_wr_idx,
    input  logic [ADDEND_WIDTH-1:0]                       i_wr_data,
    input  logic                                          i_wr_last,
    input  logic                                          i_clear,
    output buf_state_t                                    o_state,
    output logic [$clog2(NUMBER_OF_ADDENDS+1)-1:0]        o_lane_count,
    output logic [NUMBER_OF_ADDENDS*ADDEND_WIDTH-1:0]     o_lanes
);

    localparam int LCW = lane_count_width(NUMBER_OF_ADDENDS);

    buf_state_t                                r_state;
    logic [LCW-1:0]                            r_count;
    logic [NUMBER_OF_ADDENDS*ADDEND_WIDTH-1:0] r_lanes;

    // Buffer state machine; clearing zeroes lanes so unwritten lanes read as padding.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= BUF_EMPTY;
            r_count <= '0;
            r_lanes <= '0;
        end else if (i_clear) begin
            r_state <= BUF_EMPTY;
            r_count <= '0;
            r_lanes <= '0;
        end else if (i_wr_en) begin
            r_lanes[int'(i_wr_idx)*ADDEND_WIDTH +: ADDEND_WIDTH] <= i_wr_data;
            if (i_wr_last) begin
                r_state <= BUF_FULL;
                r_count <= LCW'(i_wr_idx) + LCW'(1);
            end else begin
                r_state <= BUF_FILLING;
            end
        end
    end

    assign o_state      = r_state;
    assign o_lane_count = r_count;
    assign o_lanes      = r_lanes;

endmodule

// File: rtl/addend_vector_loader.sv
// Streaming-to-parallel loader: assembles words into packed vectors using
// two ping-pong banks, so one vector fills while the other is presented.
// Handshakes: a word moves when s_valid_in && s_ready_out on a rising edge;
// a vector moves when vec_valid_out && vec_ready_in on a rising edge.
// s_ready_out depends only on registered state, never on vec_ready_in.
module addend_vector_loader
    import neural_network_pkg::*;
#(
    parameter int ADDEND_WIDTH      = 16,
    parameter int NUMBER_OF_ADDENDS = 64
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      s_valid_in,
    output logic                                      s_ready_out,
    input  logic [ADDEND_WIDTH-1:0]                   s_data_in,
    input  logic                                      s_last_in,
    output logic                                      vec_valid_out,
    input  logic                                      vec_ready_in,
    output logic [NUMBER_OF_ADDENDS*ADDEND_WIDTH-1:0] vec_data_out,
    output logic [$clog2(NUMBER_OF_ADDENDS+1)-1:0]    lane_count_out
);

    localparam int IDX_W = $clog2(NUMBER_OF_ADDENDS);
    localparam int LCW   = lane_count_width(NUMBER_OF_ADDENDS);
    localparam int VW    = NUMBER_OF_ADDENDS * ADDEND_WIDTH;

    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [IDX_W-1:0] r_wr_idx;

    buf_state_t       w_state [2];
    logic [LCW-1:0]   w_count [2];
    logic [VW-1:0]    w_lanes [2];
    logic [1:0]       w_full;
    logic [1:0]       w_wr_en;
    logic [1:0]       w_clear;
    logic             w_accept;
    logic             w_release;
    logic             w_complete;

    // Ready is held low during reset and while the write bank still holds a vector.
    assign s_ready_out = !rst_in && !w_full[r_wr_sel];
    assign w_accept    = s_valid_in && s_ready_out;
    assign w_complete  = w_accept && (s_last_in || (r_wr_idx == IDX_W'(NUMBER_OF_ADDENDS - 1)));

    assign vec_valid_out  = w_full[r_rd_sel];
    assign vec_data_out   = w_lanes[r_rd_sel];
    assign lane_count_out = w_count[r_rd_sel];
    assign w_release      = vec_valid_out && vec_ready_in;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_full[b]  = (w_state[b] == BUF_FULL);
        assign w_wr_en[b] = w_accept && (r_wr_sel == 1'(b));
        assign w_clear[b] = w_release && (r_rd_sel == 1'(b));

        addend_vector_bank #(
            .ADDEND_WIDTH      (ADDEND_WIDTH),
            .NUMBER_OF_ADDENDS (NUMBER_OF_ADDENDS)
        ) u_bank (
            .i_clk        (clk_in),
            .i_rst        (rst_in),
            .i_wr_en      (w_wr_en[b]),
            .i_wr_idx     (r_wr_idx),
            .i_wr_data    (s_data_in),
            .i_wr_last    (w_complete),
            .i_clear      (w_clear[b]),
            .o_state      (w_state[b]),
            .o_lane_count (w_count[b]),
            .o_lanes      (w_lanes[b])
        );
    end

    // Ping-pong pointers and write lane index; accept and release may coincide on different banks.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_wr_idx <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_wr_idx <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_wr_idx <= r_wr_idx + IDX_W'(1);
                end
            end
            if (w_release) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_addend_vector_loader.sv
// Bench for addend_vector_loader with 4 lanes of 16 bits.
module tb_addend_vector_loader;
  import neural_network_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int VW  = N * W;
  localparam int LCW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  logic           s_valid_in;
  logic           s_ready_out;
  logic [W-1:0]   s_data_in;
  logic           s_last_in;
  logic           vec_valid_out;
  logic           vec_ready_in;
  logic [VW-1:0]  vec_data_out;
  logic [LCW-1:0] lane_count_out;

  addend_vector_loader #(.ADDEND_WIDTH(W), .NUMBER_OF_ADDENDS(N)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .s_valid_in     (s_valid_in),
    .s_ready_out    (s_ready_out),
    .s_data_in      (s_data_in),
    .s_last_in      (s_last_in),
    .vec_valid_out  (vec_valid_out),
    .vec_ready_in   (vec_ready_in),
    .vec_data_out   (vec_data_out),
    .lane_count_out (lane_count_out)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [VW-1:0]  exp_q[$];   // complete vectors waiting for the consumer, oldest first
  logic [LCW-1:0] cnt_q[$];
  addend_t        cur_q[$];   // words of the vector being assembled
  int             emit_q[$];  // cycles in which the DUT handed over a vector
  logic           m_acc;
  logic           m_rel;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Two vector slots exist; the writer stalls only while both hold complete vectors.
  task automatic model_check();
    logic m_ready;
    logic m_valid;
    m_ready = (exp_q.size() < 2);
    m_valid = (exp_q.size() > 0);
    chk("s_ready", VW'(s_ready_out), VW'(m_ready));
    chk("vec_valid", VW'(vec_valid_out), VW'(m_valid));
    if (m_valid) begin
      chk("vec_data", vec_data_out, exp_q[0]);
      chk("lane_count", VW'(lane_count_out), VW'(cnt_q[0]));
    end
    m_acc = s_valid_in && m_ready;
    m_rel = m_valid && vec_ready_in;
    if (vec_valid_out && vec_ready_in) emit_q.push_back(cyc);
  endtask

  task automatic model_update();
    logic [VW-1:0] v;
    if (m_rel) begin
      void'(exp_q.pop_front());
      void'(cnt_q.pop_front());
    end
    if (m_acc) begin
      cur_q.push_back(s_data_in);
      if (s_last_in || cur_q.size() == N) begin
        v = '0;
        for (int i = 0; i < cur_q.size(); i++) v[i*W +: W] = cur_q[i];
        exp_q.push_back(v);
        cnt_q.push_back(LCW'(cur_q.size()));
        cur_q.delete();
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cnt_q.delete();
    cur_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle_begin(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    s_valid_in   = v;
    s_data_in    = d;
    s_last_in    = l;
    vec_ready_in = r;
    @(negedge clk);
    model_check();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    cycle_begin(v, d, l, r);
    cycle_end();
  endtask

  function automatic logic [VW-1:0] lane_sum(input logic [VW-1:0] vec);
    logic [VW-1:0] s = '0;
    for (int i = 0; i < N; i++) s = s + VW'(vec[i*W +: W]);
    return s;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic           v;
    logic [W-1:0]   d;
    logic           l;
    logic           r;
    logic           e_ready;
    logic           e_valid;
    logic [LCW-1:0] e_cnt;
    logic [VW-1:0]  e_vec;
    logic [VW-1:0]  e_sum;
  } row_t;

  row_t tbl [8];

  function automatic row_t mk(input int v, input int d, input int l, input int r,
                              input int er, input int ev, input int ec,
                              input logic [VW-1:0] evec, input int esum);
    row_t x;
    x.v = v[0]; x.d = W'(d); x.l = l[0]; x.r = r[0];
    x.e_ready = er[0]; x.e_valid = ev[0]; x.e_cnt = LCW'(ec);
    x.e_vec = evec; x.e_sum = VW'(esum);
    return x;
  endfunction

  initial begin
    int low_ready;
    logic [VW-1:0] held;

    tbl[0] = mk(1, 1, 0, 1, 1, 0, 0, '0, 0);
    tbl[1] = mk(1, 2, 0, 1, 1, 0, 0, '0, 0);
    tbl[2] = mk(1, 3, 0, 1, 1, 0, 0, '0, 0);
    tbl[3] = mk(1, 4, 0, 1, 1, 0, 0, '0, 0);
    tbl[4] = mk(1, 5, 0, 1, 1, 1, 4, 64'h0004_0003_0002_0001, 'hA);
    tbl[5] = mk(1, 7, 1, 1, 1, 0, 0, '0, 0);
    tbl[6] = mk(0, 0, 0, 1, 1, 1, 2, 64'h0000_0000_0007_0005, 'hC);
    tbl[7] = mk(0, 0, 0, 1, 1, 0, 0, '0, 0);

    // reset state
    rst_in = 1'b1; s_valid_in = 1'b0; s_data_in = '0; s_last_in = 1'b0; vec_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", VW'(s_ready_out), '0);
    chk("rst_valid", VW'(vec_valid_out), '0);
    chk("rst_data", vec_data_out, '0);
    chk("rst_count", VW'(lane_count_out), '0);
    @(negedge clk);
    rst_in = 1'b0;
    @(posedge clk);
    #1;

    // full vector and short vector from the table
    for (int i = 0; i < 8; i++) begin
      cycle_begin(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      chk("tbl_ready", VW'(s_ready_out), VW'(tbl[i].e_ready));
      chk("tbl_valid", VW'(vec_valid_out), VW'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk("tbl_data", vec_data_out, tbl[i].e_vec);
        chk("tbl_count", VW'(lane_count_out), VW'(tbl[i].e_cnt));
        chk("tbl_sum", lane_sum(vec_data_out), tbl[i].e_sum);
      end
      cycle_end();
    end

    // last without valid is ignored, then a 1-lane vector
    cycle(0, 16'h00EE, 1, 1);
    cycle(1, 16'h0042, 1, 1);
    cycle_begin(0, 0, 0, 1);
    chk("one_lane_count", VW'(lane_count_out), VW'(1));
    chk("one_lane_data", vec_data_out, 64'h0000_0000_0000_0042);
    cycle_end();
    cycle(0, 0, 0, 1);

    // backpressure: both banks fill, ninth word held off
    for (int i = 1; i <= 8; i++) cycle(1, W'(i), 0, 0);
    cycle_begin(1, 9, 0, 0);
    chk("bp_ready_low", VW'(s_ready_out), '0);
    cycle_end();
    cycle_begin(0, 0, 0, 1);
    chk("bp_first_vec", vec_data_out, 64'h0004_0003_0002_0001);
    chk("bp_ready_release", VW'(s_ready_out), '0);
    cycle_end();
    cycle_begin(0, 0, 0, 1);
    chk("bp_second_vec", vec_data_out, 64'h0008_0007_0006_0005);
    chk("bp_ready_back", VW'(s_ready_out), VW'(1));
    cycle_end();
    cycle(0, 0, 0, 1);

    // continuous stream of 12 words
    emit_q.delete();
    low_ready = 0;
    for (int i = 0; i < 12; i++) begin
      cycle_begin(1, W'(16'h0100 + i), 0, 1);
      if (!s_ready_out) low_ready++;
      cycle_end();
    end
    repeat (3) cycle(0, 0, 0, 1);
    chk("cont_ready_drops", VW'(low_ready), '0);
    chk("cont_emits", VW'(emit_q.size()), VW'(3));
    for (int i = 1; i < emit_q.size(); i++)
      chk("cont_spacing", VW'(emit_q[i] - emit_q[i-1]), VW'(4));

    // hold stability while the other bank fills
    for (int i = 1; i <= 4; i++) cycle(1, W'(i), 0, 0);
    held = 64'h0004_0003_0002_0001;
    for (int i = 0; i < 5; i++) begin
      cycle_begin(1, W'(16'h0010 + i), 0, 0);
      chk("hold_data", vec_data_out, held);
      chk("hold_count", VW'(lane_count_out), VW'(4));
      cycle_end();
    end
    repeat (4) cycle(0, 0, 0, 1);

    // asynchronous reset in the middle of a fill
    cycle(1, 16'h00AA, 0, 1);
    cycle(1, 16'h00BB, 0, 1);
    s_valid_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", VW'(vec_valid_out), '0);
    chk("mid_rst_data", vec_data_out, '0);
    chk("mid_rst_count", VW'(lane_count_out), '0);
    chk("mid_rst_ready", VW'(s_ready_out), '0);
    model_clear();
    @(negedge clk);
    rst_in = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) cycle(1, W'(i), 0, 1);
    cycle(1, 4, 0, 1);
    cycle_begin(0, 0, 0, 1);
    chk("post_rst_vec", vec_data_out, 64'h0004_0003_0002_0001);
    cycle_end();
    cycle(0, 0, 0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 1));
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
    chk("drain_empty", VW'(exp_q.size()), '0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addend_vector_loader.md
Name: addend_vector_loader

Overview:
- Streaming-to-parallel front end for the cascaded adder chain. It accepts one ADDEND_WIDTH word per cycle on a valid/ready stream and assembles each group into a packed NUMBER_OF_ADDENDS-lane vector.
- It presents that vector, with a valid/ready handshake, to the adder chain's addends_in.
- Two ping-pong buffers let the next vector fill while the current one is held at the output.
- A short vector, terminated early with s_last_in, is zero-padded so the downstream sum is unaffected.

Parameters:
- ADDEND_WIDTH, 16, width of each streamed word and each output lane.
- NUMBER_OF_ADDENDS, 64, lanes per vector; must be ≥ 2.

Ports:
- clk_in  input  1  single clock; all logic is on its rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- s_valid_in  input  1  input word valid.
- s_ready_out  output  1  loader can accept a word this cycle.
- s_data_in  input  ADDEND_WIDTH  input word.
- s_last_in  input  1  marks the final word of a vector; ends the vector early.
- vec_valid_out  output  1  a complete vector is presented.
- vec_ready_in  input  1  consumer takes the vector this cycle.
- vec_data_out  output  NUMBER_OF_ADDENDS*ADDEND_WIDTH  packed vector; lane i is bits [i*ADDEND_WIDTH +: ADDEND_WIDTH].
- lane_count_out  output  $clog2(NUMBER_OF_ADDENDS+1)  number of written lanes in the presented vector, range 1..NUMBER_OF_ADDENDS.

Behaviour:
- Reset is asynchronous and active-high: clk_in is the single clock; rst_in asserted forces state immediately.
- Reset values:
  - both buffers all-zero;
  - both full flags 0;
  - wr_sel = rd_sel = 0;
  - wr_idx = 0;
  - s_ready_out = 1 once rst_in deasserts (it is 0 while rst_in is high);
  - vec_valid_out = 0, vec_data_out = 0, lane_count_out = 0.
- Each buffer holds NUMBER_OF_ADDENDS lanes plus a full flag and a lane count.
- Per-buffer state machine:
  - EMPTY -> FILLING on the first accepted word;
  - FILLING -> FULL on accepting word index NUMBER_OF_ADDENDS-1 or any word with s_last_in=1;
  - FULL -> EMPTY on the output handshake.
- Input side:
  - s_ready_out = !full[wr_sel], purely from registered state (no combinational path from vec_ready_in).
  - An accept is s_valid_in && s_ready_out. It writes s_data_in to lane wr_idx of buffer wr_sel and increments wr_idx.
  - On the completing accept: set full[wr_sel], store lane count wr_idx+1, reset wr_idx to 0, toggle wr_sel.
  - s_last_in on the first word gives a 1-lane vector.
  - s_last_in with s_valid_in low is ignored.
- Output side:
  - vec_valid_out = full[rd_sel]; vec_data_out and lane_count_out come from buffer rd_sel.
  - On vec_valid_out && vec_ready_in: clear full[rd_sel], zero all lanes and the count of that buffer, toggle rd_sel.
  - Unwritten lanes are therefore always 0 (zero padding).
- Latency: the completing word accepted at edge t gives vec_valid_out=1 after edge t (visible in cycle t+1).
- Throughput: one word per cycle sustained, with no bubble at the vector boundary while the other buffer is EMPTY.
- Held output: vec_data_out and lane_count_out stay stable while vec_valid_out=1 and vec_ready_in=0.
- Both buffers full: s_ready_out=0 until a release. In the release cycle s_ready_out stays 0; it rises the following cycle.
- Simultaneous events:
  - A completing accept into one buffer and a release of the other buffer in the same cycle are both performed.
  - An accept and a release never target the same buffer.
- Reset mid-fill or mid-hold: all partial and full data is discarded; no vector is emitted afterwards.
- No arithmetic on the data; words pass unmodified. wr_idx is $clog2(NUMBER_OF_ADDENDS) bits wide.

Decomposition:
- Shared package neural_network_pkg holds:
  - typedef addend_t as logic [ADDEND_WIDTH-1:0];
  - function lane_count_width(n) returning $clog2(n+1).
- One sub-module, addend_vector_bank: a single buffer with write-lane port, clear, full flag and lane count. It is instantiated twice. Ping-pong select and handshake logic stay in the top.

Test Plan (NUMBER_OF_ADDENDS=4, ADDEND_WIDTH=16):
- Full vector: stream 0x0001, 0x0002, 0x0003, 0x0004 back-to-back with vec_ready_in=1 -> one cycle after the 4th accept, vec_valid_out=1, lanes {1,2,3,4}, lane_count_out=4; adder chain sum = 0x000A.
- Short vector: stream 0x0005, then 0x0007 with s_last_in=1 -> lanes {5,7,0,0}, lane_count_out=2.
- Backpressure: vec_ready_in=0, stream 8 words (1..8) -> s_ready_out falls after the 8th accept; a 9th word is held off. Raise vec_ready_in -> vectors {1,2,3,4} then {5,6,7,8} in order; s_ready_out returns 1 the cycle after the first release.
- Continuous stream of 12 words with vec_ready_in=1 -> s_ready_out never drops; three vectors emitted 4 cycles apart.
- Reset mid-fill: accept 0x00AA, 0x00BB, assert rst_in asynchronously -> outputs zero immediately. Stream 0x0001..0x0004 -> vector {1,2,3,4}, with no trace of 0xAA or 0xBB.
- Hold stability: vec_valid_out=1, vec_ready_in=0 for 5 cycles while new words fill the other buffer -> vec_data_out and lane_count_out unchanged throughout.
